// File: rtl/div_rate_ctrl.sv
// Run/pause/stop sequencer with a four-level rate selector.
// Rate changes take effect only at a terminal count while running.
module div_rate_ctrl #(
    parameter int               WIDTH  = 27,
    parameter logic [WIDTH-1:0] LIMIT0 = 27'd49_999_999,
    parameter logic [WIDTH-1:0] LIMIT1 = 27'd24_999_999,
    parameter logic [WIDTH-1:0] LIMIT2 = 27'd12_499_999,
    parameter logic [WIDTH-1:0] LIMIT3 = 27'd6_249_999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             speed_up,
    input  logic             speed_down,
    output logic             signal,
    output logic             tick,
    output logic             running,
    output logic [1:0]       speed_level,
    output logic [WIDTH-1:0] limit
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             sig_q, sig_d;
    logic             tick_q, tick_d;
    logic [1:0]       lvl_q, lvl_d;
    logic [1:0]       pend_q, pend_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            limit_q <= LIMIT0;
            sig_q   <= 1'b0;
            tick_q  <= 1'b0;
            lvl_q   <= 2'd0;
            pend_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            limit_q <= limit_d;
            sig_q   <= sig_d;
            tick_q  <= tick_d;
            lvl_q   <= lvl_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sig_d   = sig_q;
        tick_d  = 1'b0;
        lvl_d   = lvl_q;
        pend_d  = pend_q;
        limit_d = limit_q;

        // Opposing presses in one cycle cancel out
        if (speed_up && !speed_down && pend_q != 2'd3) begin
            pend_d = pend_q + 2'd1;
        end else if (speed_down && !speed_up && pend_q != 2'd0) begin
            pend_d = pend_q - 2'd1;
        end

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                sig_d = 1'b0;
                lvl_d = pend_d;
                if (start && !stop) state_d = RUN;
            end
            RUN: begin
                if (stop) begin
                    state_d = PAUSE;
                end else if (cnt_q >= limit_q) begin
                    cnt_d  = '0;
                    sig_d  = ~sig_q;
                    tick_d = 1'b1;
                    lvl_d  = pend_d;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            PAUSE: begin
                lvl_d = pend_d;
                if (stop) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    sig_d   = 1'b0;
                end else if (start) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                sig_d   = 1'b0;
            end
        endcase

        unique case (lvl_d)
            2'd0: limit_d = LIMIT0;
            2'd1: limit_d = LIMIT1;
            2'd2: limit_d = LIMIT2;
            2'd3: limit_d = LIMIT3;
            default: limit_d = LIMIT0;
        endcase
    end

    assign signal      = sig_q;
    assign tick        = tick_q;
    assign running     = (state_q == RUN);
    assign speed_level = lvl_q;
    assign limit       = limit_q;

endmodule

// File: tb/tb_div_rate_ctrl.sv
// Directed bench for div_rate_ctrl with small limits (3,2,1,0).
// Every cycle is scored against a queued expectation from a cycle model.
module tb_div_rate_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        speed_up = 1'b0;
    logic        speed_down = 1'b0;
    logic        sig_o;
    logic        tick_o;
    logic        run_o;
    logic [1:0]  lvl_o;
    logic [26:0] lim_o;

    div_rate_ctrl #(
        .WIDTH (27),
        .LIMIT0(27'd3),
        .LIMIT1(27'd2),
        .LIMIT2(27'd1),
        .LIMIT3(27'd0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .speed_up   (speed_up),
        .speed_down (speed_down),
        .signal     (sig_o),
        .tick       (tick_o),
        .running    (run_o),
        .speed_level(lvl_o),
        .limit      (lim_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] v;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    int   LIM [4] = '{3, 2, 1, 0};
    int   m_state, m_cnt, m_lvl, m_pend;
    logic m_sig, m_tick;

    function automatic logic [31:0] pack_out();
        return {sig_o, tick_o, run_o, lvl_o, lim_o};
    endfunction

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_lvl = 0; m_pend = 0;
        m_sig = 1'b0; m_tick = 1'b0;
    endtask

    task automatic model_step(input logic st, sp, up, dn);
        int np;
        np = m_pend;
        if (up && !dn && np < 3) np++;
        else if (dn && !up && np > 0) np--;
        m_tick = 1'b0;
        case (m_state)
            0: begin
                m_lvl = np;
                if (st && !sp) m_state = 1;
            end
            1: begin
                if (sp) m_state = 2;
                else if (m_cnt >= LIM[m_lvl]) begin
                    m_cnt = 0; m_sig = ~m_sig; m_tick = 1'b1; m_lvl = np;
                end else m_cnt++;
            end
            default: begin
                m_lvl = np;
                if (sp) begin
                    m_state = 0; m_cnt = 0; m_sig = 1'b0;
                end else if (st) m_state = 1;
            end
        endcase
        m_pend = np;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic st, sp, up, dn, input string tag);
        exp_t e;
        @(negedge clk);
        start = st; stop = sp; speed_up = up; speed_down = dn;
        model_step(st, sp, up, dn);
        e.v   = {m_sig, m_tick, (m_state == 1), 2'(m_lvl), 27'(LIM[m_lvl])};
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0; stop = 1'b0; speed_up = 1'b0; speed_down = 1'b0;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk(e.tag, pack_out(), e.v);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", pack_out(), {1'b0, 1'b0, 1'b0, 2'd0, 27'd3});
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, "idle");
        chk("idle_lim", 32'(lim_o), 32'd3);
        chk("idle_run", 32'(run_o), 32'd0);

        // Level 0: tick every 4 cycles, signal period 8
        step(1, 0, 0, 0, "start0");
        chk("start_run", 32'(run_o), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 0, 0, "run0");
            chk("t0_tick", 32'(tick_o), 32'(i == 4 || i == 8));
            chk("t0_sig", 32'(sig_o), 32'(i >= 4 && i < 8));
        end

        // Pause at cnt=2, frozen for 10 cycles, resume ticks 2 edges later
        step(0, 0, 0, 0, "c1");
        step(0, 0, 0, 0, "c2");
        step(0, 1, 0, 0, "stop_p");
        chk("pause_run", 32'(run_o), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, "pause");
            chk("pause_tick", 32'(tick_o), 32'd0);
        end
        step(1, 0, 0, 0, "resume");
        step(0, 0, 0, 0, "res1");
        chk("res1_tick", 32'(tick_o), 32'd0);
        step(0, 0, 0, 0, "res2");
        chk("res2_tick", 32'(tick_o), 32'd1);

        // speed_up at cnt=1: level switches at the next tick
        step(0, 0, 0, 0, "c1b");
        step(0, 0, 1, 0, "up_run");
        chk("up_lvl_hold", 32'(lvl_o), 32'd0);
        for (int j = 1; j <= 8; j++) begin
            step(0, 0, 0, 0, "run1");
            chk("t1_tick", 32'(tick_o), 32'(j == 2 || j == 5 || j == 8));
            chk("t1_lvl", 32'(lvl_o), (j >= 2) ? 32'd1 : 32'd0);
        end

        step(0, 1, 0, 0, "stop1");
        step(0, 1, 0, 0, "stop2");
        chk("idle_sig", 32'(sig_o), 32'd0);
        chk("idle_run2", 32'(run_o), 32'd0);

        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, "up6");
        chk("sat_lvl", 32'(lvl_o), 32'd3);
        chk("sat_lim", 32'(lim_o), 32'd0);
        step(1, 0, 0, 0, "start3");
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, "run3");
            chk("t3_tick", 32'(tick_o), 32'd1);
        end
        step(0, 1, 0, 0, "stop3a");
        step(0, 1, 0, 0, "stop3b");

        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, "down3");
        chk("down_lvl", 32'(lvl_o), 32'd0);
        step(0, 0, 0, 1, "down_sat");
        chk("down_sat", 32'(lvl_o), 32'd0);
        step(0, 0, 1, 0, "up1");
        step(0, 0, 1, 1, "updown");
        chk("updown_lvl", 32'(lvl_o), 32'd1);
        step(0, 0, 0, 1, "down0");

        // Downshift in PAUSE leaves cnt above the new limit
        step(1, 0, 0, 0, "start_p");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, "cnt3");
        step(0, 1, 0, 0, "stop_c3");
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, "up_pause");
        chk("pause_lvl", 32'(lvl_o), 32'd3);
        step(1, 0, 0, 0, "resume3");
        chk("resume3_tick", 32'(tick_o), 32'd0);
        step(0, 0, 0, 0, "first");
        chk("first_tick", 32'(tick_o), 32'd1);
        chk("first_sig", 32'(sig_o), 32'd1);
        step(0, 0, 0, 0, "second");

        // Asynchronous reset mid-cycle
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("async_rst", pack_out(), {1'b0, 1'b0, 1'b0, 2'd0, 27'd3});
        @(negedge clk);
        rst = 1'b1;
        step(0, 0, 0, 0, "post_rst");
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
